// File: rtl/aes_dec_sequencer.sv
// Purpose: sequences an SPI-fed AES-256 decrypt: collects ciphertext and key, runs the inverse cipher, streams plaintext back.
// Latency: inv_start one cycle after the last key byte; first plaintext byte on tx_byte the cycle after inv_done.
// Backpressure: byte-paced by rx_valid/tx_ack pulses; frame_active low aborts load/send; cipher wait bounded by TIMEOUT.
module aes_dec_sequencer #(
    parameter int BLK_BYTES = 16,
    parameter int KEY_BYTES = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_active,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic [7:0]             tx_byte,
    input  logic                   tx_ack,
    output logic [BLK_BYTES*8-1:0] ct_out,
    output logic [KEY_BYTES*8-1:0] key_out,
    output logic                   inv_start,
    input  logic                   inv_done,
    input  logic [BLK_BYTES*8-1:0] pt_in,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int MAX_BK = (BLK_BYTES > KEY_BYTES) ? BLK_BYTES : KEY_BYTES;
    localparam int MAX_N  = (MAX_BK > TIMEOUT) ? MAX_BK : TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_N + 1);
    localparam int BLK_W  = BLK_BYTES * 8;
    localparam int KEY_W  = KEY_BYTES * 8;

    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_BYTES - 1);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_CT  = 3'd1;
    localparam logic [2:0] S_LOAD_KEY = 3'd2;
    localparam logic [2:0] S_START    = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_SEND     = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] tmo_cnt;
    logic [BLK_W-1:0] pt_sh;

    // Start pulse lasts exactly the single START cycle; busy covers every non-IDLE state.
    assign inv_start = (state == S_START);
    assign busy      = (state != S_IDLE);

    // Sequencer state, byte counters and data registers. Ciphertext and key are
    // shifted in at the low end so byte 0 lands in the top byte once the block is full;
    // plaintext is shifted out from the top so tx_byte always shows the next byte to send.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            count   <= '0;
            tmo_cnt <= '0;
            tx_byte <= '0;
            ct_out  <= '0;
            key_out <= '0;
            pt_sh   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A byte arriving as the frame drops is not the start of a new frame.
                    if (rx_valid && frame_active) begin
                        ct_out <= {ct_out[BLK_W-9:0], rx_byte};
                        count  <= CNT_W'(1);
                        err    <= 1'b0;
                        state  <= S_LOAD_CT;
                    end
                end
                S_LOAD_CT: begin
                    if (!frame_active) begin
                        count <= '0;
                        state <= S_IDLE;
                    end else if (rx_valid) begin
                        ct_out <= {ct_out[BLK_W-9:0], rx_byte};
                        if (count == BLK_LAST) begin
                            count <= '0;
                            state <= S_LOAD_KEY;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_LOAD_KEY: begin
                    if (!frame_active) begin
                        count <= '0;
                        state <= S_IDLE;
                    end else if (rx_valid) begin
                        key_out <= {key_out[KEY_W-9:0], rx_byte};
                        if (count == KEY_LAST) begin
                            count <= '0;
                            state <= S_START;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the final timeout cycle still wins.
                    if (inv_done) begin
                        pt_sh   <= pt_in;
                        tx_byte <= pt_in[BLK_W-1 -: 8];
                        count   <= '0;
                        state   <= S_SEND;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err     <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (!frame_active) begin
                        count <= '0;
                        state <= S_IDLE;
                    end else if (tx_ack) begin
                        if (count == BLK_LAST) begin
                            done  <= 1'b1;
                            count <= '0;
                            state <= S_IDLE;
                        end else begin
                            count   <= count + 1'b1;
                            pt_sh   <= pt_sh << 8;
                            tx_byte <= pt_sh[BLK_W-9 -: 8];
                        end
                    end
                end
                default: begin
                    count <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Purpose: directed self-checking bench for aes_dec_sequencer (nominal, abort, timeout, race, reset, ignored inputs).
// Latency: inputs driven 1ns after rising edges, outputs sampled 1ns after rising edges.
// Backpressure: n/a; every step is a fixed number of cycles.
module tb_aes_dec_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_active;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic [7:0]   tx_byte;
    logic         tx_ack;
    logic [127:0] ct_out;
    logic [255:0] key_out;
    logic         inv_start;
    logic         inv_done;
    logic [127:0] pt_in;
    logic         busy;
    logic         done;
    logic         err;

    int n_chk  = 0;
    int n_err  = 0;
    int n_start = 0;
    int n_done  = 0;
    int snap_start;
    int snap_done;

    aes_dec_sequencer #(.BLK_BYTES(16), .KEY_BYTES(32), .TIMEOUT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_active (frame_active),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .tx_byte      (tx_byte),
        .tx_ack       (tx_ack),
        .ct_out       (ct_out),
        .key_out      (key_out),
        .inv_start    (inv_start),
        .inv_done     (inv_done),
        .pt_in        (pt_in),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Pulse counters for the one-cycle outputs, sampled mid-cycle.
    always @(negedge clk) begin
        if (inv_start) n_start++;
        if (done)      n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Loads 16 ciphertext bytes then 32 key bytes; optionally pulses tx_ack during the key phase.
    task automatic load_frame(input logic [127:0] ct, input logic [255:0] key, input bit ack_noise);
        for (int i = 0; i < 16; i++) send_byte(ct[127-8*i -: 8]);
        for (int i = 0; i < 32; i++) begin
            tx_ack = ack_noise && (i == 3 || i == 17);
            send_byte(key[255-8*i -: 8]);
            tx_ack = 1'b0;
        end
    endtask

    // Walks the 16 plaintext bytes with acks, checking each presented byte and the done pulse.
    task automatic run_send(input string tag, input logic [127:0] pt, input logic [127:0] ct);
        logic [127:0] p;
        p = pt;
        for (int i = 0; i < 16; i++) begin
            check({tag, "_tx"}, 256'(tx_byte), 256'(p[127-8*i -: 8]));
            if (i == 5) begin
                rx_byte  = 8'h77;
                rx_valid = 1'b1;
                tick();
                rx_valid = 1'b0;
                check({tag, "_ct_hold_send"}, 256'(ct_out), 256'(ct));
            end
            tx_ack = 1'b1;
            tick();
            tx_ack = 1'b0;
        end
        check({tag, "_done"}, 256'(done), 256'(1'b1));
        check({tag, "_idle"}, 256'(busy), 256'(1'b0));
        tick();
        check({tag, "_done_pulse"}, 256'(done), 256'(1'b0));
    endtask

    localparam logic [127:0] CT0  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h404142434445464748494a4b4c4d4e4f;
    localparam logic [255:0] KEY1 = 256'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0efeeedecebeae9e8e7e6e5e4e3e2e1e0;
    localparam logic [127:0] PT1  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] PT2  = 128'h5a0102030405060708090a0b0c0d0e0f;

    initial begin
        reset = 1'b1; frame_active = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0;
        tx_ack = 1'b0; inv_done = 1'b0; pt_in = '0;
        #1 reset = 1'b0;
        #2;
        // Reset state
        check("rst_busy", 256'(busy), 256'(1'b0));
        check("rst_tx", 256'(tx_byte), 256'(8'h00));
        check("rst_ct", 256'(ct_out), 256'(128'h0));
        check("rst_key", key_out, 256'h0);
        check("rst_start", 256'(inv_start), 256'(1'b0));
        check("rst_done", 256'(done), 256'(1'b0));
        check("rst_err", 256'(err), 256'(1'b0));
        tick(); tick();
        reset = 1'b1;

        // Nominal transaction with tx_ack noise during the key load
        frame_active = 1'b1;
        send_byte(CT0[127:120]);
        check("nom_busy_first", 256'(busy), 256'(1'b1));
        for (int i = 1; i < 16; i++) send_byte(CT0[127-8*i -: 8]);
        for (int i = 0; i < 32; i++) begin
            tx_ack = (i == 3 || i == 17);
            send_byte(KEY0[255-8*i -: 8]);
            tx_ack = 1'b0;
        end
        check("nom_start", 256'(inv_start), 256'(1'b1));
        check("nom_ct", 256'(ct_out), 256'(CT0));
        check("nom_key", key_out, KEY0);
        tick();
        check("nom_start_pulse", 256'(inv_start), 256'(1'b0));
        // rx_valid during WAIT must not disturb the loaded block
        send_byte(8'h33);
        send_byte(8'h44);
        check("nom_ct_hold_wait", 256'(ct_out), 256'(CT0));
        check("nom_key_hold_wait", key_out, KEY0);
        pt_in = PT0; inv_done = 1'b1;
        tick();
        inv_done = 1'b0; pt_in = '0;
        run_send("nom", PT0, CT0);
        check("nom_start_cnt", 256'(n_start), 256'(1));
        check("nom_done_cnt", 256'(n_done), 256'(1));

        // Abort after 20 bytes, with a byte coincident with frame_active falling
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        frame_active = 1'b0;
        send_byte(8'hee);
        check("abort_idle", 256'(busy), 256'(1'b0));
        tick();
        check("abort_stay_idle", 256'(busy), 256'(1'b0));
        check("abort_no_start", 256'(n_start), 256'(1));
        frame_active = 1'b1;
        load_frame(CT1, KEY1, 1'b0);
        check("abort_next_start", 256'(inv_start), 256'(1'b1));
        check("abort_next_ct", 256'(ct_out), 256'(CT1));
        check("abort_next_key", key_out, KEY1);
        tick();
        pt_in = PT1; inv_done = 1'b1;
        tick();
        inv_done = 1'b0;
        run_send("abort_next", PT1, CT1);

        // Timeout: err rises exactly 8 cycles after START exits
        load_frame(CT0, KEY0, 1'b0);
        tick();
        repeat (7) tick();
        check("tmo_err_early", 256'(err), 256'(1'b0));
        check("tmo_busy_early", 256'(busy), 256'(1'b1));
        tick();
        check("tmo_err", 256'(err), 256'(1'b1));
        check("tmo_idle", 256'(busy), 256'(1'b0));
        send_byte(8'h11);
        check("tmo_err_clear", 256'(err), 256'(1'b0));
        check("tmo_reload_busy", 256'(busy), 256'(1'b1));
        frame_active = 1'b0;
        tick();
        frame_active = 1'b1;

        // Race: inv_done on the timeout cycle wins
        load_frame(CT1, KEY1, 1'b0);
        tick();
        repeat (7) tick();
        pt_in = PT1; inv_done = 1'b1;
        tick();
        inv_done = 1'b0;
        check("race_busy", 256'(busy), 256'(1'b1));
        check("race_err", 256'(err), 256'(1'b0));
        run_send("race", PT1, CT1);

        // frame_active low during WAIT: cipher completes, SEND then aborts
        snap_done = n_done;
        load_frame(CT0, KEY0, 1'b0);
        tick();
        frame_active = 1'b0;
        tick(); tick();
        check("fwait_busy", 256'(busy), 256'(1'b1));
        pt_in = PT2; inv_done = 1'b1;
        tick();
        inv_done = 1'b0;
        check("fwait_send", 256'(busy), 256'(1'b1));
        check("fwait_tx", 256'(tx_byte), 256'(8'h5a));
        tick();
        check("fwait_abort", 256'(busy), 256'(1'b0));
        check("fwait_no_done", 256'(n_done), 256'(snap_done));
        frame_active = 1'b1;

        // Reset during WAIT: outputs clear at once, late inv_done ignored
        load_frame(CT1, KEY1, 1'b0);
        tick(); tick();
        snap_start = n_start;
        snap_done  = n_done;
        reset = 1'b0;
        #1;
        check("rwait_busy", 256'(busy), 256'(1'b0));
        check("rwait_tx", 256'(tx_byte), 256'(8'h00));
        check("rwait_ct", 256'(ct_out), 256'(128'h0));
        check("rwait_key", key_out, 256'h0);
        check("rwait_err", 256'(err), 256'(1'b0));
        pt_in = PT0; inv_done = 1'b1;
        tick();
        inv_done = 1'b0;
        reset = 1'b1;
        inv_done = 1'b1;
        tick();
        inv_done = 1'b0;
        tick();
        check("rwait_late_busy", 256'(busy), 256'(1'b0));
        check("rwait_late_tx", 256'(tx_byte), 256'(8'h00));
        check("rwait_no_start", 256'(n_start), 256'(snap_start));
        check("rwait_no_done", 256'(n_done), 256'(snap_done));
        send_byte(8'ha5);
        check("rwait_first_byte", 256'(busy), 256'(1'b1));
        frame_active = 1'b0;
        tick();
        check("rwait_end_idle", 256'(busy), 256'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
